// File: rtl/eval_pkg.sv
// -----------------------------------------------------------------------------
// eval_pkg
// Shared definitions for the classifier evaluation harness: the harness FSM
// state encoding and the default values of the harness parameters.
//   NUM_A    : features per sample
//   WIDTH_A  : bits per feature
//   OUTWIDTH : class index width
//   SETTLE   : cycles the external classifier is given to settle (>= 1)
//   CNT_W    : width of the statistics counters
// -----------------------------------------------------------------------------
package eval_pkg;

    localparam int NUM_A    = 16;
    localparam int WIDTH_A  = 4;
    localparam int OUTWIDTH = 4;
    localparam int SETTLE   = 4;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

endpackage

// File: rtl/feature_packer.sv
// -----------------------------------------------------------------------------
// feature_packer
// Collects the features of one sample into a packed bus. Feature k (arrival
// order) lands in slice [k*WIDTH_A +: WIDTH_A]; untouched slices keep their
// previous contents.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   load_i     : a feature transfers on this edge
//   data_i     : feature value
//   cls_inp_o  : packed feature bus (registered)
//   last_o     : the current slot is the final one of the sample
// -----------------------------------------------------------------------------
module feature_packer
    import eval_pkg::*;
#(
    parameter int NUM_A   = eval_pkg::NUM_A,
    parameter int WIDTH_A = eval_pkg::WIDTH_A
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic [WIDTH_A-1:0]       data_i,
    output logic [NUM_A*WIDTH_A-1:0] cls_inp_o,
    output logic                     last_o
);

    localparam int IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_A - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NUM_A*WIDTH_A-1:0] cls_q, cls_d;

    // Next slot index and slice write for the accepted feature.
    always_comb begin
        idx_d = idx_q;
        cls_d = cls_q;
        if (load_i) begin
            cls_d[int'(idx_q) * WIDTH_A +: WIDTH_A] = data_i;
            if (idx_q == IDX_LAST) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_ONE;
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Index and packed-bus registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= {IDX_W{1'b0}};
            cls_q <= {(NUM_A*WIDTH_A){1'b0}};
        end else begin
            idx_q <= idx_d;
            cls_q <= cls_d;
        end
    end

    assign cls_inp_o = cls_q;
    assign last_o    = (idx_q == IDX_LAST);

endmodule

// File: rtl/classifier_eval_harness.sv
// -----------------------------------------------------------------------------
// classifier_eval_harness
// Streams one sample of features into an external combinational classifier,
// waits a fixed settle time, captures the class and compares it with the
// expected label, then holds the result until it is consumed. Keeps
// saturating counts of samples classified and samples classified correctly.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   feat_valid/feat_ready/feat_data : feature stream (label on last beat)
//   feat_label                      : expected class for the sample
//   cls_inp / cls_out               : to / from the external classifier
//   res_valid/res_ready             : result handshake
//   res_class, res_match            : captured class and label comparison
//   clear_stats                     : zero both statistics counters
//   sample_cnt, correct_cnt         : statistics counters
// feat_ready and res_valid are registered copies of the next state, so no
// input reaches them combinationally.
// -----------------------------------------------------------------------------
module classifier_eval_harness
    import eval_pkg::*;
#(
    parameter int NUM_A    = eval_pkg::NUM_A,
    parameter int WIDTH_A  = eval_pkg::WIDTH_A,
    parameter int OUTWIDTH = eval_pkg::OUTWIDTH,
    parameter int SETTLE   = eval_pkg::SETTLE,
    parameter int CNT_W    = eval_pkg::CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     feat_valid,
    output logic                     feat_ready,
    input  logic [WIDTH_A-1:0]       feat_data,
    input  logic [OUTWIDTH-1:0]      feat_label,
    output logic [NUM_A*WIDTH_A-1:0] cls_inp,
    input  logic [OUTWIDTH-1:0]      cls_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [OUTWIDTH-1:0]      res_class,
    output logic                     res_match,
    input  logic                     clear_stats,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic [CNT_W-1:0]         correct_cnt
);

    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE - 1);
    localparam logic [SC_W-1:0]  SC_ONE      = SC_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e                state_q, state_d;
    logic [SC_W-1:0]       settle_q, settle_d;
    logic [OUTWIDTH-1:0]   label_q, label_d;
    logic [OUTWIDTH-1:0]   res_class_q, res_class_d;
    logic                  res_match_q, res_match_d;
    logic                  res_valid_q, res_valid_d;
    logic                  feat_ready_q, feat_ready_d;
    logic [CNT_W-1:0]      sample_q, sample_d;
    logic [CNT_W-1:0]      correct_q, correct_d;
    logic                  feat_xfer_s, res_xfer_s, last_s, capture_s, hit_s;

    // Handshakes qualified by the registered ready/valid, which already
    // encode LOAD and HOLD; this is what makes stray valid/ready harmless.
    assign feat_xfer_s = feat_valid & feat_ready_q;
    assign res_xfer_s  = res_ready & res_valid_q;
    assign hit_s       = (cls_out == label_q);

    feature_packer #(
        .NUM_A   (NUM_A),
        .WIDTH_A (WIDTH_A)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (feat_xfer_s),
        .data_i    (feat_data),
        .cls_inp_o (cls_inp),
        .last_o    (last_s)
    );

    // FSM next state, settle counter and registered handshake outputs.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        capture_s = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (feat_xfer_s && last_s) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    capture_s = 1'b1;
                    settle_d  = {SC_W{1'b0}};
                    state_d   = ST_HOLD;
                end else begin
                    settle_d  = settle_q + SC_ONE;
                end
            end
            ST_HOLD: begin
                if (res_xfer_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d  = ST_LOAD;
                settle_d = {SC_W{1'b0}};
            end
        endcase
        feat_ready_d = (state_d == ST_LOAD);
        res_valid_d  = (state_d == ST_HOLD);
    end

    // Label sampling on the last beat and result capture at end of settle.
    always_comb begin
        label_d     = label_q;
        res_class_d = res_class_q;
        res_match_d = res_match_q;
        if (feat_xfer_s && last_s) begin
            label_d = feat_label;
        end else begin
            label_d = label_q;
        end
        if (capture_s) begin
            res_class_d = cls_out;
            res_match_d = hit_s;
        end else begin
            res_class_d = res_class_q;
            res_match_d = res_match_q;
        end
    end

    // Saturating statistics; a clear overrides a same-cycle capture.
    always_comb begin
        sample_d  = sample_q;
        correct_d = correct_q;
        if (clear_stats) begin
            sample_d  = {CNT_W{1'b0}};
            correct_d = {CNT_W{1'b0}};
        end else if (capture_s) begin
            if (sample_q != CNT_MAX) begin
                sample_d = sample_q + CNT_ONE;
            end else begin
                sample_d = sample_q;
            end
            if (hit_s && (correct_q != CNT_MAX)) begin
                correct_d = correct_q + CNT_ONE;
            end else begin
                correct_d = correct_q;
            end
        end else begin
            sample_d  = sample_q;
            correct_d = correct_q;
        end
    end

    // State, result and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            settle_q     <= {SC_W{1'b0}};
            label_q      <= {OUTWIDTH{1'b0}};
            res_class_q  <= {OUTWIDTH{1'b0}};
            res_match_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            feat_ready_q <= 1'b1;
            sample_q     <= {CNT_W{1'b0}};
            correct_q    <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            label_q      <= label_d;
            res_class_q  <= res_class_d;
            res_match_q  <= res_match_d;
            res_valid_q  <= res_valid_d;
            feat_ready_q <= feat_ready_d;
            sample_q     <= sample_d;
            correct_q    <= correct_d;
        end
    end

    assign feat_ready  = feat_ready_q;
    assign res_valid   = res_valid_q;
    assign res_class   = res_class_q;
    assign res_match   = res_match_q;
    assign sample_cnt  = sample_q;
    assign correct_cnt = correct_q;

endmodule

// File: tb/tb_classifier_eval_harness.sv
// -----------------------------------------------------------------------------
// tb_classifier_eval_harness
// Directed bench for classifier_eval_harness. A default instance and a second
// instance with 2-bit counters share every input, so the saturation behaviour
// can be observed alongside the normal counts. Inputs change and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_classifier_eval_harness;

    localparam int ST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        feat_valid;
    logic [3:0]  feat_data;
    logic [3:0]  feat_label;
    logic        res_ready;
    logic        clear_stats;
    logic [3:0]  cls_ret;

    logic        feat_ready, res_valid, res_match;
    logic [63:0] cls_inp;
    logic [3:0]  res_class;
    logic [15:0] sample_cnt, correct_cnt;

    logic        feat_ready2, res_valid2, res_match2;
    logic [63:0] cls_inp2;
    logic [3:0]  res_class2;
    logic [1:0]  sample_cnt2, correct_cnt2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_edge = 0;

    always #5 clk = ~clk;

    // Edge counter used to measure result latency.
    always @(posedge clk) cyc <= cyc + 1;

    classifier_eval_harness dut (
        .clk(clk), .rst(rst), .feat_valid(feat_valid), .feat_ready(feat_ready),
        .feat_data(feat_data), .feat_label(feat_label), .cls_inp(cls_inp),
        .cls_out(cls_ret), .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_match(res_match), .clear_stats(clear_stats),
        .sample_cnt(sample_cnt), .correct_cnt(correct_cnt)
    );

    classifier_eval_harness #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .feat_valid(feat_valid), .feat_ready(feat_ready2),
        .feat_data(feat_data), .feat_label(feat_label), .cls_inp(cls_inp2),
        .cls_out(cls_ret), .res_valid(res_valid2), .res_ready(res_ready),
        .res_class(res_class2), .res_match(res_match2), .clear_stats(clear_stats),
        .sample_cnt(sample_cnt2), .correct_cnt(correct_cnt2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one feature and wait (bounded) for it to transfer; returns at
    // the falling edge after the transfer edge, recorded in last_edge.
    task automatic send_feat(input logic [3:0] d, input logic [3:0] lbl);
        bit acc;
        int budget;
        feat_valid = 1'b1;
        feat_data  = d;
        feat_label = lbl;
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 20) begin
            acc = (feat_ready === 1'b1);
            @(negedge clk);
            budget++;
        end
        feat_valid = 1'b0;
        if (!acc) check_eq("feat_timeout", 64'd0, 64'd1);
        last_edge = cyc;
    endtask

    // Whole sample. mode 0: k, 1: 15-k, 2: 3k mod 16, 3: k+1 mod 16.
    task automatic send_sample(input int mode, input logic [3:0] lbl, input bit gap);
        logic [3:0] v;
        for (int k = 0; k < 16; k++) begin
            case (mode)
                0:       v = 4'(k);
                1:       v = 4'(15 - k);
                2:       v = 4'(3 * k);
                default: v = 4'(k + 1);
            endcase
            send_feat(v, (k == 15) ? lbl : 4'hF);
            if (gap && k != 15) @(negedge clk);
        end
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("latency", 64'(cyc - last_edge), 64'(ST));
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq("res_valid_cleared", 64'(res_valid), 64'd0);
        check_eq("feat_ready_back", 64'(feat_ready), 64'd1);
    endtask

    // Global time bound.
    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; feat_valid = 1'b0; feat_data = 4'd0; feat_label = 4'd0;
        res_ready = 1'b0; clear_stats = 1'b0; cls_ret = 4'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_cls_inp", cls_inp, 64'd0);
        check_eq("rst_res_valid", 64'(res_valid), 64'd0);
        check_eq("rst_res_class", 64'(res_class), 64'd0);
        check_eq("rst_sample", 64'(sample_cnt), 64'd0);
        check_eq("rst_correct", 64'(correct_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_feat_ready", 64'(feat_ready), 64'd1);

        // Single matching sample
        cls_ret = 4'd7;
        send_sample(0, 4'd7, 1'b0);
        check_eq("t1_cls_inp", cls_inp, 64'hFEDCBA9876543210);
        check_eq("t1_settle_not_ready", 64'(feat_ready), 64'd0);
        wait_result();
        check_eq("t1_class", 64'(res_class), 64'd7);
        check_eq("t1_match", 64'(res_match), 64'd1);
        check_eq("t1_sample", 64'(sample_cnt), 64'd1);
        check_eq("t1_correct", 64'(correct_cnt), 64'd1);
        consume();

        // Label mismatch
        cls_ret = 4'd3;
        send_sample(1, 4'd5, 1'b0);
        check_eq("t2_cls_inp", cls_inp, 64'h0123456789ABCDEF);
        wait_result();
        check_eq("t2_class", 64'(res_class), 64'd3);
        check_eq("t2_match", 64'(res_match), 64'd0);
        check_eq("t2_sample", 64'(sample_cnt), 64'd2);
        check_eq("t2_correct", 64'(correct_cnt), 64'd1);
        consume();

        // Backpressure in HOLD with feat_valid asserted
        cls_ret = 4'd9;
        send_sample(2, 4'd9, 1'b0);
        wait_result();
        cls_ret = 4'd0;
        feat_valid = 1'b1;
        feat_data = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("t3_feat_ready", 64'(feat_ready), 64'd0);
            check_eq("t3_res_valid", 64'(res_valid), 64'd1);
            check_eq("t3_class", 64'(res_class), 64'd9);
            check_eq("t3_cls_inp", cls_inp, 64'hDA741EB852FC9630);
        end
        feat_valid = 1'b0;
        consume();
        check_eq("t3_sample", 64'(sample_cnt), 64'd3);
        check_eq("t3_correct", 64'(correct_cnt), 64'd2);
        @(negedge clk);
        check_eq("t3_single_xfer", 64'(res_valid), 64'd0);
        check_eq("t3_sample_after", 64'(sample_cnt), 64'd3);

        // Reset mid-sample
        for (int k = 0; k < 6; k++) send_feat(4'(k), 4'hF);
        check_eq("t4_partial", cls_inp, 64'hDA741EB852543210);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t4_cls_inp", cls_inp, 64'd0);
        check_eq("t4_sample", 64'(sample_cnt), 64'd0);
        check_eq("t4_correct", 64'(correct_cnt), 64'd0);
        check_eq("t4_feat_ready", 64'(feat_ready), 64'd1);
        cls_ret = 4'd2;
        send_sample(3, 4'd2, 1'b0);
        check_eq("t4_new_cls_inp", cls_inp, 64'h0FEDCBA987654321);
        wait_result();
        check_eq("t4_match", 64'(res_match), 64'd1);
        check_eq("t4_sample_new", 64'(sample_cnt), 64'd1);
        consume();

        // Gapped input, then clear and reset while holding a result
        cls_ret = 4'd4;
        send_sample(1, 4'd4, 1'b1);
        check_eq("t5_cls_inp", cls_inp, 64'h0123456789ABCDEF);
        wait_result();
        check_eq("t5_match", 64'(res_match), 64'd1);
        check_eq("t5_sample", 64'(sample_cnt), 64'd2);
        check_eq("t5_correct", 64'(correct_cnt), 64'd2);
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        check_eq("t5_clr_sample", 64'(sample_cnt), 64'd0);
        check_eq("t5_clr_correct", 64'(correct_cnt), 64'd0);
        check_eq("t5_clr_hold", 64'(res_valid), 64'd1);
        check_eq("t5_clr_class", 64'(res_class), 64'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t5_rst_valid", 64'(res_valid), 64'd0);
        check_eq("t5_rst_class", 64'(res_class), 64'd0);
        check_eq("t5_rst_match", 64'(res_match), 64'd0);
        check_eq("t5_rst_ready", 64'(feat_ready), 64'd1);

        // Saturation on the 2-bit instance
        cls_ret = 4'd1;
        for (int n = 1; n <= 5; n++) begin
            send_sample(0, 4'd1, 1'b0);
            wait_result();
            check_eq("t6_sat_sample", 64'(sample_cnt2), 64'((n < 3) ? n : 3));
            check_eq("t6_sat_correct", 64'(correct_cnt2), 64'((n < 3) ? n : 3));
            check_eq("t6_wide_sample", 64'(sample_cnt), 64'(n));
            consume();
        end
        send_sample(0, 4'd1, 1'b0);
        while (cyc < last_edge + ST - 1) @(negedge clk);
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        check_eq("t6_capture_edge", 64'(res_valid2), 64'd1);
        check_eq("t6_clr_sample", 64'(sample_cnt2), 64'd0);
        check_eq("t6_clr_correct", 64'(correct_cnt2), 64'd0);
        check_eq("t6_clr_wide", 64'(sample_cnt), 64'd0);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/classifier_eval_harness.md
CLASSIFIER_EVAL_HARNESS -- requirements
Module: classifier_eval_harness

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_A, 16, features per sample.
- WIDTH_A, 4, bits per feature.
- OUTWIDTH, 4, class index width.
- SETTLE, 4, cycles allowed for the classifier to settle (>=1).
- CNT_W, 16, statistics counter width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- feat_valid, in, 1, feature beat valid.
- feat_ready, out, 1, harness accepts a feature.
- feat_data, in, WIDTH_A, feature value.
- feat_label, in, OUTWIDTH, expected class; sampled on the last feature beat only.
- cls_inp, out, NUM_A*WIDTH_A, packed feature bus to the combinational classifier.
- cls_out, in, OUTWIDTH, classifier result.
- res_valid, out, 1, result available.
- res_ready, in, 1, result consumed.
- res_class, out, OUTWIDTH, captured classifier result.
- res_match, out, 1, res_class equals the sampled label.
- clear_stats, in, 1, zero the statistics counters.
- sample_cnt, out, CNT_W, samples classified.
- correct_cnt, out, CNT_W, samples with res_match=1.

Function
REQ-003 A feature transfers on a rising edge with feat_valid=1 and feat_ready=1.
REQ-004 Feature k of a sample (k=0..NUM_A-1, arrival order) is written to cls_inp[(k+1)*WIDTH_A-1 : k*WIDTH_A]; all other slices hold.
REQ-005 FSM states: LOAD, SETTLE, HOLD.
REQ-006 LOAD: feat_ready=1. The feature index increments per transfer. The transfer with index NUM_A-1 samples feat_label, resets the index to 0, and moves the FSM to SETTLE.
REQ-007 SETTLE: feat_ready=0 and cls_inp is stable. A settle counter runs 0..SETTLE-1. At the end of count SETTLE-1, cls_out is captured into res_class, res_match=(cls_out==label) is captured, and the FSM moves to HOLD.
REQ-008 Latency: if the last feature transfers on edge T, res_valid goes high after edge T+SETTLE.
REQ-009 HOLD: res_valid=1 and feat_ready=0. res_class, res_match and cls_inp are stable until a transfer with res_valid=1 and res_ready=1. That transfer returns the FSM to LOAD and clears res_valid on the same edge.
REQ-010 sample_cnt increments on each SETTLE-to-HOLD capture. correct_cnt also increments when the captured res_match=1. Both counters saturate at 2^CNT_W-1 (no wrap).
REQ-011 clear_stats=1 zeroes both counters on the next edge. Clear wins over a simultaneous increment. clear_stats has no effect on the FSM or the datapath.
REQ-012 feat_valid is ignored outside LOAD. res_ready is ignored outside HOLD.
REQ-013 All outputs are registered. No combinational path runs from any input to feat_ready or res_valid.

Reset
REQ-014 rst=1 on an edge sets: FSM=LOAD, feature index=0, settle counter=0, cls_inp=0, res_valid=0, res_class=0, res_match=0, label=0, sample_cnt=0, correct_cnt=0.
REQ-015 Reset mid-sample or mid-HOLD discards the partial sample or pending result without incrementing counters. feat_ready=1 on the first cycle after rst deasserts.

Structure
REQ-016 A shared package eval_pkg holds:
- the FSM state enum;
- the default parameter constants NUM_A, WIDTH_A, OUTWIDTH, SETTLE and CNT_W.
REQ-017 One sub-module, feature_packer, owns the index counter and the cls_inp slice writes.
REQ-018 The FSM, settle counter and statistics logic live in classifier_eval_harness.
REQ-019 The classifier itself is external and is connected only through cls_inp and cls_out.

Verification
REQ-020 Single sample, defaults, features 0..15 back-to-back, classifier model returns 7, label 7. Required response: cls_inp=64'hFEDCBA9876543210; res_valid rises after edge T+4; res_class=7; res_match=1; sample_cnt=1; correct_cnt=1.
REQ-021 Label mismatch, classifier returns 3, label 5. Required response: res_match=0; sample_cnt increments; correct_cnt unchanged.
REQ-022 Backpressure, res_ready held 0 for 10 cycles in HOLD while feat_valid=1. Required response: feat_ready=0 throughout; results stable; exactly one result transfer when res_ready=1; then LOAD.
REQ-023 Reset mid-sample, rst after 6 features. Required response: cls_inp=0; counters 0; next 16 features form a complete sample indexed from slot 0.
REQ-024 Saturation with CNT_W=2, 5 matching samples. Required response: sample_cnt=3 and correct_cnt=3 after the 3rd sample and thereafter; clear_stats asserted on a capture edge yields 0.
REQ-025 Gapped input, feat_valid toggled 1/0 per cycle. Required response: slots filled in order with no skips; latency still measured from the last transfer edge.
